// File: rtl/cw_fields_pkg.sv
// Shared control-word field map and execute-stage FSM encoding.
// Used by the control unit, the execute unit and the instruction-specific units.
package cw_fields_pkg;

   localparam int unsigned CW_LENGTH  = 40;
   localparam int unsigned MEM_EN_BIT = 24;
   localparam int unsigned MEM_WE_BIT = 23;
   localparam int unsigned SL_BIT     = 22;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } cw_state_e;

endpackage

// File: rtl/cw_mem_wait_fsm.sv
// Memory-wait sequencer: state register, hold/mem_req generation and, with
// CW_MEM_TIMEOUT_EN defined, a MEM_WAIT timeout counter that traps into FAULT.
module cw_mem_wait_fsm
   import cw_fields_pkg::*;
`ifdef CW_MEM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
   input  logic clock_i,
   input  logic reset_i,
   input  logic mem_en_i,
   input  logic wait_we_i,
   input  logic mem_ready_i,
   output logic hold_o,
   output logic mem_req_o,
   output logic mem_we_o,
   output logic fault_o,
   output logic accept_o,
   output logic run_o,
   output logic wait_o
);

   cw_state_e state_q, state_d;

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= ST_RUN;
      else         state_q <= state_d;
   end

`ifdef CW_MEM_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES);
   logic [7:0] tmo_q, tmo_d;

   // Held at zero outside MEM_WAIT, so it is always clear on entry.
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_MEM_WAIT) begin
         tmo_d = mem_ready_i ? tmo_q : tmo_q + 8'd1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (mem_en_i) state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: begin
            if (mem_ready_i) state_d = ST_RUN;
`ifdef CW_MEM_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) state_d = ST_FAULT;
`endif
         end
         ST_FAULT:    state_d = ST_FAULT;
         default:     state_d = ST_RUN;
      endcase
   end

   always_comb begin
      hold_o    = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      fault_o   = 1'b0;
      accept_o  = 1'b0;
      run_o     = 1'b0;
      wait_o    = 1'b0;
      case (state_q)
         ST_RUN: begin
            run_o    = 1'b1;
            hold_o   = mem_en_i;
            accept_o = !mem_en_i;
         end
         ST_MEM_WAIT: begin
            wait_o    = 1'b1;
            mem_req_o = 1'b1;
            mem_we_o  = wait_we_i;
            hold_o    = !mem_ready_i;
            accept_o  = mem_ready_i;
         end
         ST_FAULT: begin
            hold_o  = 1'b1;
`ifdef CW_MEM_TIMEOUT_EN
            fault_o = 1'b1;
`endif
         end
         default: hold_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cw_execute_unit.sv
// Execute-stage control word register, status flags and accepted-word counter.
// Optional memory timeout/FAULT trap enabled by defining CW_MEM_TIMEOUT_EN.
module cw_execute_unit #(
   parameter int unsigned CW_LENGTH = cw_fields_pkg::CW_LENGTH
`ifdef CW_MEM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [CW_LENGTH-1:0] control_word,
   input  logic [3:0]           alu_flags,
   input  logic                 alu_zero,
   input  logic                 mem_ready,
   output logic [4:0]           status,
   output logic                 hold,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [CW_LENGTH-1:0] cw_active,
   output logic [15:0]          cw_count,
   output logic                 fault
);

   logic [CW_LENGTH-1:0] cw_active_q, cw_active_d;
   logic [CW_LENGTH-1:0] acc_word;
   logic [3:0]           flags_q, flags_d;
   logic [15:0]          count_q, count_d;
   logic                 accept, in_run, in_wait;

   cw_mem_wait_fsm
`ifdef CW_MEM_TIMEOUT_EN
      #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
   u_fsm (
      .clock_i     (clock),
      .reset_i     (reset),
      .mem_en_i    (control_word[cw_fields_pkg::MEM_EN_BIT]),
      .wait_we_i   (cw_active_q[cw_fields_pkg::MEM_WE_BIT]),
      .mem_ready_i (mem_ready),
      .hold_o      (hold),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .fault_o     (fault),
      .accept_o    (accept),
      .run_o       (in_run),
      .wait_o      (in_wait)
   );

   // The word accepted in MEM_WAIT is the frozen one, not whatever is on the input.
   assign acc_word = in_wait ? cw_active_q : control_word;

   always_comb begin
      cw_active_d = in_run ? control_word : cw_active_q;
      flags_d     = flags_q;
      count_d     = count_q;
      if (accept) begin
         count_d = count_q + 16'd1;
         if (acc_word[cw_fields_pkg::SL_BIT]) flags_d = alu_flags;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cw_active_q <= '0;
         flags_q     <= '0;
         count_q     <= '0;
      end else begin
         cw_active_q <= cw_active_d;
         flags_q     <= flags_d;
         count_q     <= count_d;
      end
   end

   assign status    = {alu_zero, flags_q};
   assign cw_active = cw_active_q;
   assign cw_count  = count_q;

endmodule

// File: doc/cw_execute_unit.md
CW_EXECUTE_UNIT -- requirements
Module: cw_execute_unit

Interface
REQ-001 Parameter CW_LENGTH, default 40: control word width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum MEM_WAIT cycles; used only when CW_MEM_TIMEOUT_EN is defined.
REQ-003 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port control_word, input, CW_LENGTH: control word currently driven by the control unit.
REQ-006 Port alu_flags, input, 4: {V,C,N,Z} from the ALU, current cycle.
REQ-007 Port alu_zero, input, 1: live ALU zero result.
REQ-008 Port mem_ready, input, 1: memory completion strobe.
REQ-009 Port status, output, 5: {alu_zero, V_q, C_q, N_q, Z_q}; this is the control unit's status input.
REQ-010 Port hold, output, 1: stall request; the control unit keeps its state while it is high.
REQ-011 Port mem_req, output, 1: memory access request.
REQ-012 Port mem_we, output, 1: write qualifier for mem_req.
REQ-013 Port cw_active, output, CW_LENGTH: registered control word presented to the datapath.
REQ-014 Port cw_count, output, 16: count of accepted control words.
REQ-015 Port fault, output, 1: memory timeout indication.

Function
REQ-016 Control word fields used by this block: CW[24] MEM_EN, CW[23] MEM_WE, CW[22] SL (status load); all other bits pass through untouched.
REQ-017 The FSM has three states: RUN, MEM_WAIT, FAULT; FAULT is reachable only with CW_MEM_TIMEOUT_EN.
REQ-018 RUN: cw_active loads control_word every cycle.
REQ-019 RUN with MEM_EN=1: hold=1 combinationally in the same cycle; next state is MEM_WAIT.
REQ-020 RUN with MEM_EN=0: hold=0; the state stays RUN.
REQ-021 MEM_WAIT: cw_active is frozen; mem_req=1; mem_we=cw_active[23]; hold=!mem_ready.
REQ-022 MEM_WAIT with mem_ready=1: hold=0 that cycle, and the next state is RUN, so a new word is presented and the access is never re-issued.
REQ-023 Minimum memory-word latency is 2 cycles (RUN issue cycle plus MEM_WAIT completion cycle).
REQ-024 A word is accepted in any cycle with hold=0 and state not FAULT.
REQ-025 On acceptance, if SL=1 of the word being accepted, {V_q,C_q,N_q,Z_q} load alu_flags; otherwise they hold.
REQ-026 For a word with SL=1 and MEM_EN=1, flags load only on the MEM_WAIT completion cycle.
REQ-027 On acceptance, cw_count increments by 1 and wraps from 16'hFFFF to 0.
REQ-028 mem_ready outside MEM_WAIT is ignored.
REQ-029 status[4] is combinational from alu_zero; status[3:0] are registered.

Reset
REQ-030 reset has priority over every other event, including mid-MEM_WAIT and FAULT.
REQ-031 Reset values: state RUN, cw_active 0, flags 0, cw_count 0, timeout counter 0, mem_req 0, fault 0.
REQ-032 The cycle after reset, hold depends only on control_word[24].

Configuration
REQ-033 Macro CW_MEM_TIMEOUT_EN defined: an 8-bit counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without mem_ready.
REQ-034 With CW_MEM_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES and mem_ready=0, the next state is FAULT.
REQ-035 FAULT: mem_req=0, hold=1, fault=1, no acceptance; FAULT is left only by reset.
REQ-036 Macro CW_MEM_TIMEOUT_EN undefined: MEM_WAIT waits indefinitely; fault is tied to 0; no counter logic exists.

Structure
REQ-037 The shared package cw_fields_pkg holds CW_LENGTH, the MEM_EN/MEM_WE/SL bit indices, and the FSM state encoding; the control unit and the instruction-specific units share it.
REQ-038 One sub-module, cw_mem_wait_fsm, contains the state register, hold/mem_req generation and the timeout counter; flags, cw_active and cw_count stay in the top level.

Verification
REQ-039 Bench covers: reset, then control_word with MEM_EN=0 and SL=1, alu_flags=4'b1010 -> next cycle status[3:0]=1010, cw_count=1, hold never asserted.
REQ-040 Bench covers: word with MEM_EN=1, MEM_WE=1, mem_ready asserted 3 cycles after issue -> hold high for 3 cycles, mem_req and mem_we high during MEM_WAIT, cw_count +1 only on the completion cycle.
REQ-041 Bench covers: MEM_EN=1 with SL=1, alu_flags changing 0001->0100 during the wait -> flags captured as 0100 on the completion cycle.
REQ-042 Bench covers: cw_count preloaded by 65535 acceptances, then one more -> cw_count=0.
REQ-043 Bench covers: reset asserted during MEM_WAIT -> next cycle state RUN, mem_req=0, flags=0, cw_count=0.
REQ-044 Bench covers, with CW_MEM_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, mem_ready held low -> FAULT after the 5th wait cycle; fault=1, hold=1, mem_req=0 until reset.
